// File: rtl/frogger_pkg.sv
// Shared screen geometry, FSM state encoding and button-priority helper for the frog controller.
package frogger_pkg;

  localparam int TILE_SIZE      = 32;
  localparam int H_VISIBLE_AREA = 640;
  localparam int V_VISIBLE_AREA = 480;
  localparam int START_X        = 320;
  localparam int START_Y        = V_VISIBLE_AREA - TILE_SIZE;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    DEAD  = 2'd1,
    WIN   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    MOVE_NONE  = 3'd0,
    MOVE_UP    = 3'd1,
    MOVE_DOWN  = 3'd2,
    MOVE_LEFT  = 3'd3,
    MOVE_RIGHT = 3'd4
  } move_t;

  // Only one step per cycle; Up wins over Down over Left over Right.
  function automatic move_t pick_move(input logic up, input logic down,
                                      input logic left, input logic right);
    if (up)    return MOVE_UP;
    if (down)  return MOVE_DOWN;
    if (left)  return MOVE_LEFT;
    if (right) return MOVE_RIGHT;
    return MOVE_NONE;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronise and debounce one raw push button; press strobe is a single cycle on a debounced rise.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles to the strobe; no backpressure.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      o_Level <= 1'b0;
      o_Press <= 1'b0;
    end else begin
      sync_q1 <= i_Raw;
      sync_q2 <= sync_q1;
      o_Press <= 1'b0;
      // Any cycle of agreement restarts the stability window.
      if (sync_q2 == o_Level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        o_Level <= sync_q2;
        o_Press <= sync_q2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/frog_controller.sv
// Frog tile position, death/respawn and win/level tracking feeding the sprite display stage.
// Moves land one cycle after a debounced press strobe; no backpressure, outputs held between events.
module frog_controller
  import frogger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RESPAWN_CYCLES  = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_Up,
  input  logic       i_Switch_Down,
  input  logic       i_Switch_Left,
  input  logic       i_Switch_Right,
  input  logic [9:0] i_Car_X,
  input  logic [9:0] i_Car_Y,
  output logic [9:0] o_X_Position,
  output logic [9:0] o_Y_Position,
  output logic [3:0] o_Level,
  output logic       o_Dead,
  output logic       o_Win
);

  localparam logic [10:0] TILE    = 11'(TILE_SIZE);
  localparam logic [10:0] X_MAX   = 11'(H_VISIBLE_AREA - TILE_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(V_VISIBLE_AREA - TILE_SIZE);
  localparam logic [9:0]  X_START = 10'(START_X);
  localparam logic [9:0]  Y_START = 10'(START_Y);
  localparam int          RW      = $clog2(RESPAWN_CYCLES + 1);
  localparam logic [RW-1:0] RESPAWN_LAST = RW'(RESPAWN_CYCLES - 1);

  logic [3:0] press;
  logic [3:0] btn_level_unused;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Switch_Up),
    .o_Level(btn_level_unused[3]), .o_Press(press[3])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Switch_Down),
    .o_Level(btn_level_unused[2]), .o_Press(press[2])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Switch_Left),
    .o_Level(btn_level_unused[1]), .o_Press(press[1])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Switch_Right),
    .o_Level(btn_level_unused[0]), .o_Press(press[0])
  );

  logic [10:0]   fx, fy, cx, cy;
  logic [9:0]    up_y, down_y, left_x, right_x;
  logic          collision;
  move_t         move;
  state_t        state;
  logic [RW-1:0] respawn_cnt;

  // 11-bit compares so car/frog + TILE near the 10-bit limit cannot wrap.
  always_comb begin
    fx        = {1'b0, o_X_Position};
    fy        = {1'b0, o_Y_Position};
    cx        = {1'b0, i_Car_X};
    cy        = {1'b0, i_Car_Y};
    collision = (fx < cx + TILE) && (cx < fx + TILE) &&
                (fy < cy + TILE) && (cy < fy + TILE);
    up_y      = (fy < TILE) ? 10'd0 : 10'(fy - TILE);
    down_y    = (fy + TILE > Y_MAX) ? 10'(Y_MAX) : 10'(fy + TILE);
    left_x    = (fx < TILE) ? 10'd0 : 10'(fx - TILE);
    right_x   = (fx + TILE > X_MAX) ? 10'(X_MAX) : 10'(fx + TILE);
    move      = pick_move(press[3], press[2], press[1], press[0]);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= ALIVE;
      o_X_Position <= X_START;
      o_Y_Position <= Y_START;
      o_Level      <= '0;
      o_Dead       <= 1'b0;
      o_Win        <= 1'b0;
      respawn_cnt  <= '0;
    end else begin
      o_Win <= 1'b0;
      case (state)
        ALIVE: begin
          if (collision) begin
            state       <= DEAD;
            o_Dead      <= 1'b1;
            respawn_cnt <= '0;
          end else if (o_Y_Position == 10'd0) begin
            // Win bookkeeping is applied on entry so it is visible alongside the pulse.
            state        <= WIN;
            o_Win        <= 1'b1;
            o_X_Position <= X_START;
            o_Y_Position <= Y_START;
            if (o_Level != LEVEL_MAX) o_Level <= o_Level + 4'd1;
          end else begin
            case (move)
              MOVE_UP:    o_Y_Position <= up_y;
              MOVE_DOWN:  o_Y_Position <= down_y;
              MOVE_LEFT:  o_X_Position <= left_x;
              MOVE_RIGHT: o_X_Position <= right_x;
              default:    ;
            endcase
          end
        end
        DEAD: begin
          if (respawn_cnt == RESPAWN_LAST) begin
            state        <= ALIVE;
            o_Dead       <= 1'b0;
            o_X_Position <= X_START;
            o_Y_Position <= Y_START;
          end else begin
            respawn_cnt <= respawn_cnt + RW'(1);
          end
        end
        WIN:     state <= ALIVE;
        default: state <= ALIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_controller.sv
// Scoreboard bench for frog_controller with short debounce/respawn windows.
module tb_frog_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right;
  logic [9:0] car_x, car_y;
  logic [9:0] o_x, o_y;
  logic [3:0] o_level;
  logic       o_dead, o_win;

  always #5 clk = ~clk;

  frog_controller #(.DEBOUNCE_CYCLES(4), .RESPAWN_CYCLES(8)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Switch_Up(up), .i_Switch_Down(down),
    .i_Switch_Left(left), .i_Switch_Right(right),
    .i_Car_X(car_x), .i_Car_Y(car_y),
    .o_X_Position(o_x), .o_Y_Position(o_y),
    .o_Level(o_level), .o_Dead(o_dead), .o_Win(o_win)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] level;
    logic       dead;
    logic       win;
  } obs_t;

  obs_t sb[$];
  obs_t exp_v;
  int   vectors     = 0;
  int   miscompares = 0;

  localparam obs_t START = '{x: 10'd320, y: 10'd448, level: 4'd0, dead: 1'b0, win: 1'b0};

  function automatic obs_t observe();
    return '{x: o_x, y: o_y, level: o_level, dead: o_dead, win: o_win};
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("x=%0d y=%0d lvl=%0d dead=%0b win=%0b", v.x, v.y, v.level, v.dead, v.win);
  endfunction

  function automatic obs_t mk(input int x, input int y, input int lvl, input bit dead, input bit win);
    return '{x: 10'(x), y: 10'(y), level: 4'(lvl), dead: dead, win: win};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] m);
    {up, down, left, right} = m;
    tick(10);
    {up, down, left, right} = 4'b0000;
    tick(10);
  endtask

  task automatic apply_reset();
    {up, down, left, right} = 4'b0000;
    car_x = 10'd600;
    car_y = 10'd0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {up, down, left, right} = 4'b0000;
    car_x = 10'd600;
    car_y = 10'd0;
    sb.push_back(START);
    tick(3);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL reset_hold: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
    rst = 1'b0;
    sb.push_back(START);
    tick(3);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL reset_idle: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
  endtask

  task automatic test_up_hold();
    up = 1'b1;
    sb.push_back(mk(320, 448, 0, 0, 0));
    sb.push_back(mk(320, 416, 0, 0, 0));
    sb.push_back(mk(320, 416, 0, 0, 0));
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i == 6 || i == 7 || i == 10) begin
        exp_v = sb.pop_front(); vectors++;
        if (observe() !== exp_v) begin
          miscompares++;
          $display("FAIL up_latency_c%0d: got %s, want %s", i, fmt(observe()), fmt(exp_v));
        end
      end
    end
    up = 1'b0;
    tick(10);
    up = 1'b1;
    sb.push_back(mk(320, 416, 0, 0, 0));
    tick(3);
    up = 1'b0;
    tick(12);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL glitch: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
  endtask

  task automatic test_edges();
    apply_reset();
    sb.push_back(mk(0, 448, 0, 0, 0));
    repeat (10) press(4'b0010);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL walk_left: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
    sb.push_back(mk(0, 448, 0, 0, 0));
    press(4'b0010);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL clamp_left: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
    sb.push_back(mk(0, 448, 0, 0, 0));
    press(4'b0100);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL clamp_down: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
    sb.push_back(mk(0, 416, 0, 0, 0));
    press(4'b1001);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL priority_up_right: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
  endtask

  task automatic test_collision();
    apply_reset();
    right = 1'b1;
    tick(6);
    car_x = 10'd330;
    car_y = 10'd430;
    for (int i = 7; i <= 14; i++) sb.push_back(mk(320, 448, 0, 1, 0));
    sb.push_back(START);
    for (int i = 7; i <= 15; i++) begin
      tick(1);
      if (i == 9) begin
        right = 1'b0;
        car_x = 10'd600;
        car_y = 10'd0;
      end
      exp_v = sb.pop_front(); vectors++;
      if (observe() !== exp_v) begin
        miscompares++;
        $display("FAIL dead_c%0d: got %s, want %s", i, fmt(observe()), fmt(exp_v));
      end
    end
    tick(10);
  endtask

  task automatic test_win();
    int ym;
    apply_reset();
    ym = 448;
    repeat (13) begin
      press(4'b1000);
      ym = ym - 32;
    end
    sb.push_back(mk(320, ym, 0, 0, 0));
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL win_approach: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
    up = 1'b1;
    sb.push_back(mk(320, 0, 0, 0, 0));
    sb.push_back(mk(320, 448, 1, 0, 1));
    sb.push_back(mk(320, 448, 1, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      if (i >= 7) begin
        exp_v = sb.pop_front(); vectors++;
        if (observe() !== exp_v) begin
          miscompares++;
          $display("FAIL win_c%0d: got %s, want %s", i, fmt(observe()), fmt(exp_v));
        end
      end
    end
    up = 1'b0;
    tick(10);
    for (int c = 2; c <= 16; c++) begin
      sb.push_back(mk(320, 448, (c > 15) ? 15 : c, 0, 0));
      repeat (14) press(4'b1000);
      exp_v = sb.pop_front(); vectors++;
      if (observe() !== exp_v) begin
        miscompares++;
        $display("FAIL level_after_%0d: got %s, want %s", c, fmt(observe()), fmt(exp_v));
      end
    end
  endtask

  task automatic test_async_reset();
    sb.push_back(mk(320, 416, 15, 0, 0));
    press(4'b1000);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL pre_dead: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
    car_x = 10'd320;
    car_y = 10'd416;
    sb.push_back(mk(320, 416, 15, 1, 0));
    tick(3);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL dead_before_rst: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
    #3;
    rst = 1'b1;
    sb.push_back(START);
    #1;
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL async_rst: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
    car_x = 10'd600;
    car_y = 10'd0;
    tick(1);
    rst = 1'b0;
    sb.push_back(START);
    tick(3);
    exp_v = sb.pop_front(); vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL post_rst: got %s, want %s", fmt(observe()), fmt(exp_v));
    end
  endtask

  initial begin
    test_reset();
    test_up_hold();
    test_edges();
    test_collision();
    test_win();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
